// File: rtl/pong_pkg.sv
// Shared types and default sizing for the DPRAM write path of the pong video engine.
package pong_pkg;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_WRITE_CYCLES = 5;
    localparam int DEF_ADDR_W       = 16;
    localparam int DEF_DATA_W       = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } arb_state_t;

    // Index width that stays legal even for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner search: first set req bit at or above rr_ptr, wrapping to 0.
module rr_pick
    import pong_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    localparam int SUM_W = IDX_W + 1;

    logic [SUM_W-1:0]   sum_w    [NUM_REQ];
    logic [IDX_W-1:0]   cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_hit;

    // Candidate gi is the requester gi places above the pointer, modulo NUM_REQ.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        assign sum_w[gi]    = {1'b0, rr_ptr} + SUM_W'(gi);
        assign cand_idx[gi] = (sum_w[gi] >= SUM_W'(NUM_REQ))
                              ? IDX_W'(sum_w[gi] - SUM_W'(NUM_REQ))
                              : IDX_W'(sum_w[gi]);
        assign cand_hit[gi] = req[cand_idx[gi]];
    end

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                valid = 1'b1;
                idx   = cand_idx[k];
            end
        end
    end

endmodule

// File: rtl/dpram_write_arbiter.sv
// Round-robin arbiter serialising requester writes into the DPRAM write port,
// holding each write for WRITE_CYCLES cycles and acknowledging it with a single pulse.
module dpram_write_arbiter
    import pong_pkg::*;
#(
    parameter  int NUM_REQ      = DEF_NUM_REQ,
    parameter  int WRITE_CYCLES = DEF_WRITE_CYCLES,
    parameter  int ADDR_W       = DEF_ADDR_W,
    parameter  int DATA_W       = DEF_DATA_W,
    localparam int IDX_W        = idx_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      hold,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      busy,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      wrEnable,
    output logic [ADDR_W-1:0]         wrAddr,
    output logic [DATA_W-1:0]         wrData
);

    localparam int CNT_W = 4;

    arb_state_t         state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [IDX_W-1:0]   rr_ptr_reg;
    logic [IDX_W-1:0]   rr_ptr_next;
    logic [IDX_W-1:0]   grant_id_reg;
    logic               wr_en_reg;
    logic [NUM_REQ-1:0] ack_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [DATA_W-1:0]  data_reg;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
    logic [DATA_W-1:0]  data_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
        assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr_reg),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

    assign rr_ptr_next = (grant_id_reg == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id_reg + 1'b1;

    // Address/data are captured only at the grant edge, so input changes
    // during WRITE/ACK cannot disturb the write in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            rr_ptr_reg   <= '0;
            grant_id_reg <= '0;
            wr_en_reg    <= 1'b0;
            ack_reg      <= '0;
            addr_reg     <= '0;
            data_reg     <= '0;
        end else begin
            ack_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (pick_valid && !hold) begin
                        state_reg    <= WRITE;
                        cnt_reg      <= '0;
                        grant_id_reg <= pick_idx;
                        addr_reg     <= addr_arr[pick_idx];
                        data_reg     <= data_arr[pick_idx];
                        wr_en_reg    <= 1'b1;
                    end
                end
                WRITE: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_W'(WRITE_CYCLES - 1)) begin
                        state_reg <= ACK;
                        wr_en_reg <= 1'b0;
                        ack_reg   <= NUM_REQ'(1) << grant_id_reg;
                    end
                end
                ACK: begin
                    state_reg  <= IDLE;
                    rr_ptr_reg <= rr_ptr_next;
                end
                default: begin
                    state_reg <= IDLE;
                    wr_en_reg <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = (state_reg != IDLE);
    assign ack      = ack_reg;
    assign grant_id = grant_id_reg;
    assign wrEnable = wr_en_reg;
    assign wrAddr   = addr_reg;
    assign wrData   = data_reg;

endmodule

// File: doc/dpram_write_arbiter.md
DPRAM_WRITE_ARBITER -- requirements
Module: dpram_write_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of write requesters (left paddle, right paddle, ball, score).
REQ-002 Parameter WRITE_CYCLES, default 5: cycles wrEnable is held per granted write; legal range 1..15.
REQ-003 Parameter ADDR_W, default 16: DPRAM address width.
REQ-004 Parameter DATA_W, default 32: DPRAM data width.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 req  input  NUM_REQ  per-requester write request; level, held until ack.
REQ-008 req_addr  input  NUM_REQ*ADDR_W  packed addresses, requester i at slice [i*ADDR_W +: ADDR_W].
REQ-009 req_data  input  NUM_REQ*DATA_W  packed write data, same slicing rule.
REQ-010 hold  input  1  when high, no new grant issued (e.g. active video); in-flight write unaffected.
REQ-011 ack  output  NUM_REQ  one-cycle completion pulse to the served requester.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 grant_id  output  clog2(NUM_REQ)  index of the requester currently being served.
REQ-014 wrEnable  output  1  DPRAM write enable.
REQ-015 wrAddr  output  ADDR_W  DPRAM write address.
REQ-016 wrData  output  DATA_W  DPRAM write data.

Function
REQ-017 FSM states are IDLE, WRITE, ACK; all outputs are driven from registers or decoded from registered state only.
REQ-018 IDLE -> WRITE on the edge where (req != 0) and hold == 0; at that edge the winner's index, address and data are latched and cnt is cleared to 0.
REQ-019 The winner is the first set req bit found searching upward from rr_ptr, wrapping from NUM_REQ-1 to 0.
REQ-020 WRITE: wrEnable = 1, wrAddr/wrData = latched values (stable for the whole state); cnt increments each cycle; WRITE -> ACK on the edge where cnt == WRITE_CYCLES-1.
REQ-021 ACK lasts exactly one cycle: ack[grant_id] = 1, all other ack bits 0, wrEnable = 0; ACK -> IDLE unconditionally.
REQ-022 On ACK -> IDLE, rr_ptr is set to (grant_id + 1) mod NUM_REQ.
REQ-023 Latency: wrEnable first high in the cycle after the granting edge; ack high WRITE_CYCLES+1 cycles after that edge; minimum spacing between back-to-back grants is WRITE_CYCLES+2 cycles.
REQ-024 Requesters deassert req on the edge at which ack is sampled high; the arbiter requires no IDLE-cycle filtering.
REQ-025 Changes to req, req_addr, req_data or hold during WRITE or ACK have no effect on the write in flight.
REQ-026 A req dropped before being granted is silently discarded; no ack is produced.
REQ-027 In IDLE, wrEnable = 0, ack = 0, and wrAddr/wrData hold their last values.

Reset
REQ-028 On rst: state = IDLE, cnt = 0, rr_ptr = 0, grant_id = 0, wrEnable = 0, ack = 0, busy = 0, wrAddr = 0, wrData = 0.
REQ-029 rst asserted mid-WRITE aborts the write: wrEnable is low in the cycle after the reset edge, and no ack is issued for the aborted write.

Structure
REQ-030 The state enum and the default constants (NUM_REQ, WRITE_CYCLES, ADDR_W, DATA_W) live in a shared package pong_pkg.
REQ-031 The round-robin winner search is a single combinational sub-module rr_pick (inputs req and rr_ptr; outputs valid and idx).

Verification
REQ-032 Single request: req = 4'b0001, addr 0x0000, data 0x000F_00BE -> wrEnable high for 5 cycles with those values, then ack[0] pulses for 1 cycle.
REQ-033 All four requesters asserted together from reset -> service order 0,1,2,3; grants spaced exactly 7 cycles apart.
REQ-034 Requester 1 served, then req = 4'b0011 -> requester 0 served before requester 1 again (pointer wrap).
REQ-035 hold = 1 with req = 4'b0100 for 20 cycles -> wrEnable stays 0; hold drops -> grant on that edge, ack 6 cycles later.
REQ-036 rst asserted during the 3rd WRITE cycle -> wrEnable = 0 and busy = 0 in the next cycle, no ack, rr_ptr = 0.
REQ-037 req_data changed mid-WRITE (0x1234 -> 0xFFFF) -> wrData remains 0x1234 until ack.
